serial_add_sched: RTL and testbench
===================================

// Module: serial_add_sched
// PURPOSE
//   Shares a single bit-serial full adder (SUM/CO from A+B+CIN) between two
//   requesters. Arbitrates requests, runs the adder LSB-first, one bit per
//   clock, over WIDTH bits, and returns a WIDTH-bit sum plus carry-out on a
//   valid/ready result port. Sits between requester FSMs and the adder datapath.
// PARAMETERS
//   WIDTH   8   operand/sum width in bits (>=2)
// PORTS
//   CLK         in   1      clock, all logic on posedge
//   rst         in   1      synchronous reset, active-high
//   req0_valid  in   1      requester 0 has operands
//   req0_ready  out  1      requester 0 operands accepted this cycle
//   req0_a      in   WIDTH  requester 0 operand A
//   req0_b      in   WIDTH  requester 0 operand B
//   req0_cin    in   1      requester 0 carry-in
//   req1_valid  in   1      requester 1 has operands
//   req1_ready  out  1      requester 1 operands accepted this cycle
//   req1_a      in   WIDTH  requester 1 operand A
//   req1_b      in   WIDTH  requester 1 operand B
//   req1_cin    in   1      requester 1 carry-in
//   res_valid   out  1      result available
//   res_ready   in   1      consumer takes result
//   res_sum     out  WIDTH  sum
//   res_cout    out  1      final carry-out
//   res_id      out  1      requester index that owns the result
// BEHAVIOUR
//   - States: IDLE -> RUN -> DONE -> IDLE. Reset -> IDLE.
//   - Reset values: res_valid=0, res_sum=0, res_cout=0, res_id=0, bit
//     counter=0, carry reg=0, last_grant=1; reqN_ready=0 while rst=1.
//   - IDLE: grant is combinational; reqN_ready = IDLE & grantN & reqN_valid.
//     On the accepting edge: latch A, B (shift regs), carry<=cin, res_id<=N,
//     last_grant<=N, counter<=0, go RUN. At most one ready high per cycle.
//   - RUN: each edge computes bit k: sum[k]=A[k]^B[k]^carry, carry<=majority;
//     counter increments; after bit WIDTH-1 go DONE, res_cout<=final carry.
//     Exactly WIDTH RUN cycles; no request accepted in RUN or DONE.
//   - DONE: res_valid=1; res_sum/res_cout/res_id stable until res_valid &
//     res_ready edge, then IDLE, res_valid<=0. Next accept earliest 1 cycle later.
//   - Latency: res_valid rises WIDTH+1 edges after the accepting edge.
//   - Arithmetic: modulo 2^WIDTH into res_sum, overflow into res_cout only.
//   - Counter never wraps: exits RUN at WIDTH-1.
//   - rst mid-RUN/DONE: operation dropped, no result emitted, IDLE next cycle.
//   - Valid deasserted before grant: no effect; requester may withdraw in IDLE.
// CONFIGURATION
//   RR_ARB_EN defined: round-robin; when both valid in IDLE, grant the
//     requester != last_grant; a single valid requester always granted.
//   RR_ARB_EN undefined: fixed priority, requester 0 always wins ties;
//     last_grant still updated but unused.
// TESTING (WIDTH=8)
//   - req0 a=8'hFF b=8'h01 cin=0 -> res_sum=8'h00, res_cout=1, res_id=0,
//     res_valid high 9 edges after accept.
//   - req1 a=8'h5A b=8'h25 cin=1 -> res_sum=8'h80, res_cout=0, res_id=1.
//   - Both valid continuously, RR_ARB_EN on -> res_id sequence 0,1,0,1;
//     off -> 0,0,0,0 with req1_ready never high.
//   - res_ready held 0 for 5 cycles in DONE -> res_valid/res_sum stable,
//     req0_ready/req1_ready stay 0 throughout.
//   - rst pulse at 4th RUN cycle -> no res_valid; next req0 a=8'h03 b=8'h04
//     cin=0 -> res_sum=8'h07, res_cout=0.
//   - req0 valid held, res_ready tied 1 -> back-to-back accepts spaced 10 cycles.

Source files
------------

// File: rtl/serial_add_sched_if.sv
// rtl/serial_add_sched_if.sv - requester/result bundle for the shared bit-serial adder scheduler
interface serial_add_sched_if #(
    parameter int WIDTH = 8
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_cin;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_cin;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_sum;
    logic             res_cout;
    logic             res_id;

    modport master (
        output req0_valid, req0_a, req0_b, req0_cin,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_cin,
        input  req1_ready,
        input  res_valid, res_sum, res_cout, res_id,
        output res_ready
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_cin,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_cin,
        output req1_ready,
        output res_valid, res_sum, res_cout, res_id,
        input  res_ready
    );
endinterface

// File: rtl/serial_add_sched.sv
// rtl/serial_add_sched.sv - two-requester scheduler for one LSB-first bit-serial adder
// RR_ARB_EN defined: round-robin arbitration; undefined: requester 0 has fixed priority.
module serial_add_sched #(
    parameter int WIDTH = 8
) (
    input logic               CLK,
    input logic               rst,
    serial_add_sched_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             id_q, id_d;
    logic             last_grant_q, last_grant_d;

    logic grant0, grant1;
    logic accept0, accept1;
    logic bit_sum, bit_carry;
    logic last_bit;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
`ifdef RR_ARB_EN
        if (bus.req0_valid && bus.req1_valid) begin
            grant0 = last_grant_q;
            grant1 = ~last_grant_q;
        end else begin
            grant0 = bus.req0_valid;
            grant1 = bus.req1_valid;
        end
`else
        grant0 = bus.req0_valid;
        grant1 = bus.req1_valid & ~bus.req0_valid;
`endif
    end

    // Gated by rst so no requester sees an accept that the reset edge discards.
    assign accept0 = (state_q == S_IDLE) && !rst && grant0;
    assign accept1 = (state_q == S_IDLE) && !rst && grant1;

    assign bit_sum   = a_q[0] ^ b_q[0] ^ carry_q;
    assign bit_carry = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    assign last_bit  = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q      <= S_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            sum_q        <= '0;
            cnt_q        <= '0;
            carry_q      <= 1'b0;
            cout_q       <= 1'b0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            sum_q        <= sum_d;
            cnt_q        <= cnt_d;
            carry_q      <= carry_d;
            cout_q       <= cout_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept0 || accept1) state_d = S_RUN;
            S_RUN:   if (last_bit) state_d = S_DONE;
            S_DONE:  if (bus.res_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        a_d          = a_q;
        b_d          = b_q;
        sum_d        = sum_q;
        cnt_d        = cnt_q;
        carry_d      = carry_q;
        cout_d       = cout_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        if (accept0 || accept1) begin
            a_d          = accept1 ? bus.req1_a : bus.req0_a;
            b_d          = accept1 ? bus.req1_b : bus.req0_b;
            carry_d      = accept1 ? bus.req1_cin : bus.req0_cin;
            id_d         = accept1;
            last_grant_d = accept1;
            cnt_d        = '0;
        end else if (state_q == S_RUN) begin
            // Operands shift right, sum fills from the MSB end: after WIDTH bits it is aligned.
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            sum_d   = {bit_sum, sum_q[WIDTH-1:1]};
            carry_d = bit_carry;
            if (last_bit) begin
                cout_d = bit_carry;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_comb begin
        bus.req0_ready = accept0;
        bus.req1_ready = accept1;
        bus.res_valid  = (state_q == S_DONE);
        bus.res_sum    = sum_q;
        bus.res_cout   = cout_q;
        bus.res_id     = id_q;
    end
endmodule

// File: tb/tb_serial_add_sched.sv
// tb/tb_serial_add_sched.sv - randomized and directed bench for serial_add_sched against a behavioural model
module tb_serial_add_sched;
    localparam int W = 8;

    logic CLK = 1'b0;
    logic rst;
    always #5 CLK = ~CLK;

    serial_add_sched_if #(.WIDTH(W)) bus ();
    serial_add_sched #(.WIDTH(W)) dut (.CLK(CLK), .rst(rst), .bus(bus));

    // Compare-process state
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         hs_count = 0;
    bit         busy = 0;
    bit         last_g = 1;
    int         due = 0;
    int         acc_cyc = 0;
    int         first_v = 0;
    bit         vseen = 0;
    bit         rst_chk = 0;
    logic [W:0] exp_total = '0;
    bit         exp_id = 0;
    int         expired_seen = 0;
    bit         spc_have = 0;
    int         spc_last = 0;

    // Stimulus-owned controls
    bit         lit_en = 0;
    logic [W-1:0] lit_sum = '0;
    bit         lit_cout = 0;
    bit         lit_id = 0;
    int         lit_lat = 0;
    bit         seq_en = 0;
    int         seq_base = 0;
    bit         seq_exp [4];
    bit         spc_en = 0;
    int         expired_n = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(negedge CLK) begin
        logic er0, er1, ev, both;
        cyc++;
        both = bus.req0_valid && bus.req1_valid;
`ifdef RR_ARB_EN
        er0 = !busy && !rst && bus.req0_valid && !(both && last_g == 1'b0);
        er1 = !busy && !rst && bus.req1_valid && !(both && last_g == 1'b1);
`else
        er0 = !busy && !rst && bus.req0_valid;
        er1 = !busy && !rst && bus.req1_valid && !bus.req0_valid;
`endif
        ev = busy && (cyc >= due);

        chk("req0_ready", bus.req0_ready, er0);
        chk("req1_ready", bus.req1_ready, er1);
        chk("res_valid", bus.res_valid, ev);
        if (ev) begin
            chk("res_sum", bus.res_sum, exp_total[W-1:0]);
            chk("res_cout", bus.res_cout, exp_total[W]);
            chk("res_id", bus.res_id, exp_id);
        end
        if (rst_chk && !rst) begin
            chk("reset_sum", bus.res_sum, 0);
            chk("reset_cout", bus.res_cout, 0);
            chk("reset_id", bus.res_id, 0);
            rst_chk = 0;
        end
        if (expired_n != expired_seen) begin
            chk("wait_bound", expired_n, expired_seen);
            expired_seen = expired_n;
        end
        if (busy && bus.res_valid && !vseen) begin
            vseen = 1;
            first_v = cyc;
        end

        if (rst) begin
            busy = 0;
            last_g = 1;
            rst_chk = 1;
            spc_have = 0;
        end else if (busy) begin
            if (ev && bus.res_ready) begin
                if (lit_en) begin
                    chk("lit_sum", bus.res_sum, lit_sum);
                    chk("lit_cout", bus.res_cout, lit_cout);
                    chk("lit_id", bus.res_id, lit_id);
                    chk("lit_latency", first_v - acc_cyc, lit_lat);
                end
                if (seq_en && (hs_count - seq_base) < 4)
                    chk("arb_seq", bus.res_id, seq_exp[hs_count - seq_base]);
                hs_count++;
                busy = 0;
            end
        end else if (er0 || er1) begin
            busy = 1;
            exp_id = er1;
            if (er1)
                exp_total = (W+1)'(bus.req1_a) + (W+1)'(bus.req1_b) + (W+1)'(bus.req1_cin);
            else
                exp_total = (W+1)'(bus.req0_a) + (W+1)'(bus.req0_b) + (W+1)'(bus.req0_cin);
            due = cyc + W + 1;
            acc_cyc = cyc;
            vseen = 0;
            last_g = exp_id;
            if (spc_en) begin
                if (spc_have) chk("accept_spacing", cyc - spc_last, 10);
                spc_have = 1;
                spc_last = cyc;
            end else begin
                spc_have = 0;
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input int r, input bit v, input logic [W-1:0] a, input logic [W-1:0] b, input bit c);
        if (r == 0) begin
            bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_cin = c;
        end else begin
            bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_cin = c;
        end
    endtask

    task automatic send(input int r, input logic [W-1:0] a, input logic [W-1:0] b, input bit c);
        bit got;
        got = 0;
        set_req(r, 1'b1, a, b, c);
        for (int k = 0; k < 60; k++) begin
            @(negedge CLK);
            if ((r == 0) ? bus.req0_ready : bus.req1_ready) begin
                got = 1;
                break;
            end
        end
        if (!got) expired_n++;
        step();
        if (r == 0) bus.req0_valid = 1'b0; else bus.req1_valid = 1'b0;
    endtask

    task automatic wait_hs(input int target);
        for (int k = 0; k < 200; k++) begin
            if (hs_count >= target) return;
            step();
        end
        expired_n++;
    endtask

    function automatic logic [W-1:0] rnd();
        return W'($urandom());
    endfunction

    initial begin
        int h;
        bit got;
        rst = 1'b1;
        set_req(0, 1'b0, '0, '0, 1'b0);
        set_req(1, 1'b0, '0, '0, 1'b0);
        bus.res_ready = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Overflow wraps into carry-out
        bus.res_ready = 1'b1;
        lit_sum = 8'h00; lit_cout = 1; lit_id = 0; lit_lat = 9; lit_en = 1;
        h = hs_count;
        send(0, 8'hFF, 8'h01, 1'b0);
        wait_hs(h + 1);
        lit_en = 0;

        lit_sum = 8'h80; lit_cout = 0; lit_id = 1; lit_lat = 9; lit_en = 1;
        h = hs_count;
        send(1, 8'h5A, 8'h25, 1'b1);
        wait_hs(h + 1);
        lit_en = 0;
        step();

        // Both requesters held valid
`ifdef RR_ARB_EN
        seq_exp[0] = 0; seq_exp[1] = 1; seq_exp[2] = 0; seq_exp[3] = 1;
`else
        seq_exp[0] = 0; seq_exp[1] = 0; seq_exp[2] = 0; seq_exp[3] = 0;
`endif
        seq_base = hs_count;
        seq_en = 1;
        for (int k = 0; k < 100 && hs_count < seq_base + 4; k++) begin
            set_req(0, 1'b1, rnd(), rnd(), 1'($urandom()));
            set_req(1, 1'b1, rnd(), rnd(), 1'($urandom()));
            step();
        end
        if (hs_count < seq_base + 4) expired_n++;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        seq_en = 0;
        step();

        // Consumer stalls in DONE while both requesters knock
        bus.res_ready = 1'b0;
        h = hs_count;
        send(0, rnd(), rnd(), 1'b1);
        got = 0;
        for (int k = 0; k < 30; k++) begin
            if (bus.res_valid) begin got = 1; break; end
            step();
        end
        if (!got) expired_n++;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        repeat (5) step();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.res_ready = 1'b1;
        wait_hs(h + 1);
        step();

        // Reset during the 4th RUN cycle drops the operation
        send(0, rnd(), rnd(), 1'b0);
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (15) step();
        lit_sum = 8'h07; lit_cout = 0; lit_id = 0; lit_lat = 9; lit_en = 1;
        h = hs_count;
        send(0, 8'h03, 8'h04, 1'b0);
        wait_hs(h + 1);
        lit_en = 0;
        step();

        // Back-to-back throughput with res_ready tied high
        spc_en = 1;
        h = hs_count;
        for (int k = 0; k < 80 && hs_count < h + 4; k++) begin
            set_req(0, 1'b1, rnd(), rnd(), 1'($urandom()));
            step();
        end
        if (hs_count < h + 4) expired_n++;
        bus.req0_valid = 1'b0;
        spc_en = 0;
        step();

        // Random traffic with withdrawals, stalls and occasional resets
        for (int k = 0; k < 1500; k++) begin
            set_req(0, $urandom_range(0, 2) != 0, rnd(), rnd(), 1'($urandom()));
            set_req(1, $urandom_range(0, 2) != 0, rnd(), rnd(), 1'($urandom()));
            bus.res_ready = $urandom_range(0, 9) < 7;
            rst = $urandom_range(0, 149) == 0;
            step();
        end
        rst = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.res_ready = 1'b1;
        repeat (20) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
